// File: rtl/cnt4_sync_pkg.sv
// rtl/cnt4_sync_pkg.sv - shared width and flop reset-value encoding for cnt4_sync
package cnt4_sync_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    RST_TO_0 = 1'b0,
    RST_TO_1 = 1'b1
  } rst_val_e;

  // Picks the per-bit reset encoding for flop i out of a counter-wide reset value.
  function automatic rst_val_e rst_bit(input logic [CNT_W-1:0] val, input int idx);
    return rst_val_e'(val[idx]);
  endfunction

endpackage

// File: rtl/cnt4_sync_dffr_sync.sv
// rtl/cnt4_sync_dffr_sync.sv - 1-bit D flop with synchronous active-low reset to a per-instance value
module dffr_sync
  import cnt4_sync_pkg::*;
#(
  parameter rst_val_e RST_BIT = RST_TO_0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= logic'(RST_BIT);
    else         q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/cnt4_sync.sv
// rtl/cnt4_sync.sv - 4-bit synchronous counter with clear, load, enable, terminal count and carry
module cnt4_sync
  import cnt4_sync_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 4'h0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             LD,
  input  logic             EN,
  input  logic [CNT_W-1:0] D,
  output logic [CNT_W-1:0] Q,
  output logic             TC,
  output logic             CO
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;
  logic [CNT_W-1:0] inc;
  logic [CNT_W:0]   carry;
  logic             hold_sel;
  logic             ld_sel;
  logic             co_q;
  logic             co_d;

  // Ripple carry chain: carry[i] is high when EN and all lower bits are ones.
  assign carry[0] = EN;
  for (genvar i = 0; i < CNT_W; i++) begin : g_carry
    assign carry[i+1] = ~(~(carry[i] & q_q[i]));
  end

  assign inc      = q_q ^ carry[CNT_W-1:0];
  assign hold_sel = ~(CLR | LD);
  assign ld_sel   = LD & ~CLR;

  // AND-OR mux: with LD low the D term is forced to zero whatever D carries.
  assign q_d = ({CNT_W{ld_sel}} & D) | ({CNT_W{hold_sel}} & inc);

  assign TC   = carry[CNT_W] & hold_sel;
  assign co_d = TC;

  for (genvar i = 0; i < CNT_W; i++) begin : g_q
    dffr_sync #(
      .RST_BIT(rst_bit(RST_VAL, i))
    ) u_q (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .d_i   (q_d[i]),
      .q_o   (q_q[i])
    );
  end

  dffr_sync #(
    .RST_BIT(RST_TO_0)
  ) u_co (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   (co_d),
    .q_o   (co_q)
  );

  assign Q  = q_q;
  assign CO = co_q;

endmodule

// File: tb/tb_cnt4_sync.sv
// tb/tb_cnt4_sync.sv - self-checking bench for cnt4_sync
module tb_cnt4_sync;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       ld;
  logic       en;
  logic [3:0] d;
  logic [3:0] d_hi;
  logic [3:0] a_q, lo_q, hi_q;
  logic       a_tc, lo_tc, hi_tc;
  logic       a_co, lo_co, hi_co;

  int checks;
  int errors;

  cnt4_sync #(.RST_VAL(4'h5)) u_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .LD(ld), .EN(en), .D(d),
    .Q(a_q), .TC(a_tc), .CO(a_co)
  );

  cnt4_sync #(.RST_VAL(4'h0)) u_lo (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .LD(ld), .EN(en), .D(d),
    .Q(lo_q), .TC(lo_tc), .CO(lo_co)
  );

  cnt4_sync #(.RST_VAL(4'h0)) u_hi (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .LD(ld), .EN(lo_tc), .D(d_hi),
    .Q(hi_q), .TC(hi_tc), .CO(hi_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] m_q;
    logic       m_co;
    logic       m_tc;
    int         co_cnt;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    ld     = 1'b0;
    en     = 1'b0;
    d      = 4'h0;
    d_hi   = 4'h0;

    // Reset for two edges
    tick();
    tick();
    check("rst_a_q", a_q, 8'h5);
    check("rst_a_co", a_co, 8'h0);
    check("rst_a_tc", a_tc, 8'h0);
    check("rst_lo_q", lo_q, 8'h0);

    // First edge after reset counts; 16 increments wrap back to 0
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("cnt_tc", lo_tc, 8'(i == 15));
      tick();
      check("cnt_q", lo_q, 8'((i + 1) % 16));
      check("cnt_co", lo_co, 8'(i == 15));
    end
    check("cnt_hi_q", hi_q, 8'h1);
    check("cnt_a_q", a_q, 8'h5);
    check("cnt_a_co", a_co, 8'h0);

    // Idle: hold Q, drop CO
    en = 1'b0;
    #1;
    check("idle_tc", lo_tc, 8'h0);
    tick();
    check("idle_q", lo_q, 8'h0);
    check("idle_co", lo_co, 8'h0);

    // Load beats enable, clear beats load
    ld = 1'b1; d = 4'h7;
    tick();
    check("ld7_q", lo_q, 8'h7);
    d = 4'hA; en = 1'b1;
    tick();
    check("ldA_q", lo_q, 8'hA);
    check("ldA_co", lo_co, 8'h0);
    clr = 1'b1;
    tick();
    check("clr_q", lo_q, 8'h0);
    check("clr_a_q", a_q, 8'h0);

    // Load F with EN high: no increment; TC masks on LD and CLR
    clr = 1'b0; d = 4'hF;
    tick();
    check("ldF_q", lo_q, 8'hF);
    check("ldF_co", lo_co, 8'h0);
    #1;
    check("tc_ld", lo_tc, 8'h0);
    ld = 1'b0;
    #1;
    check("tc_en", lo_tc, 8'h1);
    clr = 1'b1;
    #1;
    check("tc_clr", lo_tc, 8'h0);
    clr = 1'b0; en = 1'b0;
    #1;
    check("tc_noen", lo_tc, 8'h0);
    en = 1'b1;
    tick();
    check("wrap_q", lo_q, 8'h0);
    check("wrap_co", lo_co, 8'h1);
    en = 1'b0;
    tick();
    check("co_drop", lo_co, 8'h0);
    check("co_drop_q", lo_q, 8'h0);

    // Reset at F with EN high: no wrap reported
    ld = 1'b1; d = 4'hF;
    tick();
    check("preF_a_q", a_q, 8'hF);
    ld = 1'b0; en = 1'b1; rst_n = 1'b0;
    tick();
    check("rstF_a_q", a_q, 8'h5);
    check("rstF_a_co", a_co, 8'h0);
    check("rstF_lo_q", lo_q, 8'h0);
    check("rstF_lo_co", lo_co, 8'h0);

    // Reset discards a simultaneous load
    ld = 1'b1; d = 4'h9;
    tick();
    check("rst_ld_a_q", a_q, 8'h5);

    // Reset asserted mid-cycle acts only at the edge
    rst_n = 1'b1; ld = 1'b0; en = 1'b1;
    tick();
    check("mid_pre_q", a_q, 8'h6);
    rst_n = 1'b0;
    #2;
    check("mid_hold_q", a_q, 8'h6);
    tick();
    check("mid_rst_q", a_q, 8'h5);

    // Clear beats a pending wrap
    rst_n = 1'b1; ld = 1'b1; d = 4'hF; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1; clr = 1'b1;
    tick();
    check("clrwrap_q", lo_q, 8'h0);
    check("clrwrap_co", lo_co, 8'h0);

    // Two chained stages form an 8-bit counter
    clr = 1'b0; en = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b1;
    co_cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      check("chain_q", {hi_q, lo_q}, 8'(k % 256));
      if (hi_co) co_cnt++;
    end
    check("chain_co_cnt", 8'(co_cnt), 8'h1);
    check("chain_co_last", hi_co, 8'h1);

    // Randomised run against a mod-16 reference
    rst_n = 1'b0; en = 1'b0;
    tick();
    m_q  = 4'h0;
    m_co = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      ld    = ($urandom_range(0, 5) == 0);
      en    = ($urandom_range(0, 3) != 0);
      d     = 4'($urandom_range(0, 15));
      #1;
      m_tc = (m_q == 4'hF) && en && !ld && !clr;
      check("rnd_tc", lo_tc, 8'(m_tc));
      if (!rst_n) begin
        m_q = 4'h0; m_co = 1'b0;
      end else if (clr) begin
        m_q = 4'h0; m_co = 1'b0;
      end else if (ld) begin
        m_q = d; m_co = 1'b0;
      end else if (en) begin
        m_co = (m_q == 4'hF);
        m_q  = m_q + 4'h1;
      end else begin
        m_co = 1'b0;
      end
      tick();
      check("rnd_q", lo_q, 8'(m_q));
      check("rnd_co", lo_co, 8'(m_co));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
